// File: rtl/asyn_fifo_wr_ctrl.sv
// rtl/asyn_fifo_wr_ctrl.sv - write-domain burst controller feeding an async FIFO write port
// Two-entry skid buffer decouples the source; bursts start only below almost-full.
module asyn_fifo_wr_ctrl #(
  parameter int DATA_WIDTH = 18,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_wr_i,
  input  logic                  wrst_n_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  input  logic                  fifo_full_i,
  input  logic                  fifo_af_i,
  output logic                  fifo_wr_o,
  output logic [DATA_WIDTH-1:0] fifo_data_o,
  output logic                  burst_done_o,
  output logic [CNT_WIDTH-1:0]  wr_count_o
);

  localparam int BCW = $clog2(BURST_LEN + 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, BURST, HOLD} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q [2];
  logic                  last_q [2];
  logic                  head_q, tail_q;
  logic [1:0]            count_q, count_d;
  logic [BCW-1:0]        burst_cnt_q;
  logic                  push, pop, burst_end;

  assign push        = s_valid_i & s_ready_o;
  assign fifo_wr_o   = (state_q == BURST) & (count_q != 2'd0) & ~fifo_full_i;
  assign pop         = fifo_wr_o;
  assign fifo_data_o = data_q[head_q];
  // A burst ends on a word flagged last or on the BURST_LEN-th write, whichever comes first.
  assign burst_end   = pop & (last_q[head_q] | (burst_cnt_q == BURST_LAST));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if ((count_q != 2'd0) && !fifo_af_i) state_d = BURST;
      BURST: begin
        if ((count_q != 2'd0) && fifo_full_i) state_d = HOLD;
        else if (burst_end)                   state_d = IDLE;
      end
      HOLD:  if (!fifo_full_i) state_d = BURST;
      default: state_d = IDLE;
    endcase
  end

  // Payload storage is not reset: it is only observed while count_q > 0.
  always_ff @(posedge clk_wr_i) begin
    if (push) begin
      data_q[tail_q] <= s_data_i;
      last_q[tail_q] <= s_last_i;
    end
  end

  always_ff @(posedge clk_wr_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      state_q      <= IDLE;
      count_q      <= 2'd0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      burst_cnt_q  <= '0;
      s_ready_o    <= 1'b0;
      burst_done_o <= 1'b0;
      wr_count_o   <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      s_ready_o    <= (count_d != 2'd2);
      burst_done_o <= burst_end;
      if (push) tail_q <= ~tail_q;
      if (pop) begin
        head_q      <= ~head_q;
        wr_count_o  <= wr_count_o + CNT_WIDTH'(1);
        burst_cnt_q <= burst_end ? '0 : burst_cnt_q + BCW'(1);
      end
    end
  end

endmodule

// File: doc/asyn_fifo_wr_ctrl.md
Name: asyn_fifo_wr_ctrl

Overview:
Write-side controller that sits in the clk_wr_i domain in front of the asynchronous FIFO's write port.
- Accepts a valid/ready source stream into a 2-entry skid buffer.
- Issues FIFO write strobes in bursts that start only when the FIFO is not almost-full, and stalls on full.
- Reports burst completion and a running write count for the producer and for debug.

Parameters:
DATA_WIDTH, 18, width of stream/FIFO data word
BURST_LEN, 16, maximum words per burst (>=1)
CNT_WIDTH, 16, width of the wrapping write counter

Ports:
clk_wr_i  input  1  write-domain clock
wrst_n_i  input  1  reset, asynchronous, active-low
s_valid_i  input  1  source word valid
s_data_i  input  DATA_WIDTH  source word
s_last_i  input  1  source word ends a burst early
s_ready_o  output  1  controller can accept a word (registered)
fifo_full_i  input  1  FIFO full, active-high, already in write domain
fifo_af_i  input  1  FIFO almost-full, active-high, write domain
fifo_wr_o  output  1  FIFO write strobe (combinational)
fifo_data_o  output  DATA_WIDTH  FIFO write data (skid head, combinational)
burst_done_o  output  1  one-cycle pulse after the final write of a burst
wr_count_o  output  CNT_WIDTH  total FIFO writes issued, wraps modulo 2^CNT_WIDTH

Behaviour:
Reset (wrst_n_i=0, asynchronous):
- Skid buffer count 0, FSM IDLE, burst counter 0.
- s_ready_o=0, burst_done_o=0, wr_count_o=0. fifo_wr_o=0 because the skid buffer is empty.
- s_ready_o rises on the first clk_wr_i edge after reset release.

Skid buffer:
- 2 entries, FIFO order. Each entry holds {data, last}.
- push = s_valid_i & s_ready_o. pop = fifo_wr_o.
- Push and pop in the same cycle: count unchanged; head advances, new word goes to tail.
- s_ready_o register <= (count_next != 2). The buffer can never overflow.
- A push while s_ready_o=0 is ignored, with no state change.

FSM states: IDLE, BURST, HOLD.
- IDLE -> BURST: count>0 and fifo_af_i=0. No writes are issued in IDLE.
- BURST: fifo_wr_o = (count>0) & ~fifo_full_i. fifo_data_o = head data.
- BURST -> HOLD: fifo_full_i=1 and count>0. No write that cycle.
- HOLD -> BURST: fifo_full_i=0. Writes resume on the cycle after the transition.
- BURST -> IDLE: a write occurs with head.last=1, or the burst counter reaches BURST_LEN on that write. Whichever happens first ends the burst.
- Source empty in BURST: stay in BURST and wait. There is no timeout.

Burst counter:
- Width $clog2(BURST_LEN+1).
- Increments on each write and clears on the burst-ending write.

Flags and counters:
- burst_done_o is registered: it is 1 in the cycle after the burst-ending write.
- wr_count_o increments by 1 per fifo_wr_o and wraps from 2^CNT_WIDTH-1 to 0.

Almost-full:
- fifo_af_i is only consulted at burst start.
- Inside a burst, only fifo_full_i throttles.

Reset mid-burst:
- Buffered words are discarded and the FSM returns to IDLE.
- A partial burst is not completed and no burst_done_o pulse is produced.

fifo_data_o:
- Holds the head entry whenever count>0. It is don't-care when count=0; the bench must not check it then.

Test Plan:
- Reset then 20 back-to-back words 0..19, last=0, af=0, full=0 -> bursts of 16 and 4 (4th pending until more data).
  - 16 consecutive fifo_wr_o, then one IDLE cycle, then words 16..19 written.
  - burst_done_o pulses once after word 15.
  - wr_count_o=20.
- Word stream with s_last_i on the 3rd word -> exactly 3 writes, then IDLE.
  - burst_done_o pulses 1 cycle after the 3rd write.
  - The next word starts a new burst with burst counter 0.
- fifo_full_i=1 for 5 cycles after the 4th write of a burst -> FSM enters HOLD with no writes.
  - s_ready_o drops once 2 words are buffered.
  - After full=0, writes resume 1 cycle later.
  - Data order is preserved and the burst ends after 16 total writes.
- fifo_af_i=1 with 2 words buffered -> FSM stays IDLE and fifo_wr_o=0 indefinitely.
  - Lowering af starts a burst on the next edge, with the first write in the following cycle.
- Assert wrst_n_i mid-burst, asynchronous to clk_wr_i -> fifo_wr_o, s_ready_o, burst_done_o and wr_count_o all go to 0 immediately.
  - After release, s_ready_o=1 after 1 edge and no stale word is written.
- CNT_WIDTH=4, 17 writes -> wr_count_o wraps 15->0 and ends at 1.
  - Random s_valid_i/fifo_full_i toggling: scoreboard shows no lost or duplicated words.
